// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: word-to-bit serializer (MSB first) with one-entry holding register; SER_PARITY_EN appends an even-parity bit
module serial_bit_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_hreg, r_sreg;
  logic [CW-1:0]    r_cnt;
  logic             r_hold_full, r_rst_q;
  logic             w_accept, w_last, w_end, w_xfer;
`ifdef SER_PARITY_EN
  logic             r_par;
`endif
  // next state: transfer whenever a word is held and the shifter is free
  always_comb begin
    w_accept = load_valid && load_ready;
    w_last   = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
`ifdef SER_PARITY_EN
    w_end    = (r_state == PARITY);
`else
    w_end    = w_last;
`endif
    w_xfer   = r_hold_full && ((r_state == IDLE) || w_end);
`ifdef SER_PARITY_EN
    w_next   = w_xfer ? SHIFT : w_last ? PARITY : ((r_state == IDLE) || w_end) ? IDLE : r_state;
`else
    w_next   = w_xfer ? SHIFT : ((r_state == IDLE) || w_end) ? IDLE : r_state;
`endif
  end
  // state register; r_rst_q keeps load_ready low while reset is held
  always_ff @(posedge clk) begin
    r_state <= reset ? IDLE : w_next;
    r_rst_q <= reset;
  end
  // holding register: filled on accept, emptied on transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hreg      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hreg      <= data_in;
      r_hold_full <= 1'b1;
    end else if (w_xfer) begin
      r_hold_full <= 1'b0;
    end
  end
  // shifter and bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (w_xfer) begin
      r_sreg <= r_hreg;
      r_cnt  <= '0;
    end else if (r_state == SHIFT) begin
      r_sreg <= r_sreg << 1;
      r_cnt  <= r_cnt + CW'(1);
    end
  end
`ifdef SER_PARITY_EN
  // parity of the word latched as it enters the shifter
  always_ff @(posedge clk) begin
    if (reset) r_par <= 1'b0;
    else if (w_xfer) r_par <= ^r_hreg;
  end
  assign ser_out = (r_state == SHIFT) ? r_sreg[WIDTH-1] : (r_state == PARITY) ? r_par : 1'b0;
`else
  assign ser_out = (r_state == SHIFT) ? r_sreg[WIDTH-1] : 1'b0;
`endif
  assign ser_valid   = (r_state != IDLE);
  assign frame_start = (r_state == SHIFT) && (r_cnt == '0);
  assign busy        = (r_state != IDLE) || r_hold_full;
  assign load_ready  = !r_hold_full && !r_rst_q;
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: vector table, corner sequences and random traffic against a bit-queue reference model
module tb_serial_bit_feeder;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic clk = 0, rst = 1, lv = 0;
  logic [W-1:0] din = '0;
  logic load_ready, ser_out, ser_valid, frame_start, busy;
  serial_bit_feeder #(.WIDTH(W)) dut (
    .clk(clk), .reset(rst), .data_in(din), .load_valid(lv), .load_ready(load_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start), .busy(busy)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  bit mq[$];
  bit mhv = 0, mrq = 1;
  logic [W-1:0] mhw = '0;
  typedef struct {bit rst; bit lv; logic [W-1:0] d; bit rdy; bit v; bit o; bit fs; bit bsy;} vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_edge();
    bit acc;
    if (rst) begin
      mq.delete();
      mhv = 0;
      mrq = 1;
    end else begin
      acc = lv && !mhv && !mrq;
      mrq = 0;
      if (mq.size() > 0) void'(mq.pop_front());
      if (mq.size() == 0 && mhv) begin
        for (int i = W - 1; i >= 0; i--) mq.push_back(mhw[i]);
        if (P == 1) mq.push_back(^mhw);
        mhv = 0;
      end
      if (acc) begin
        mhv = 1;
        mhw = din;
      end
    end
  endtask
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("m_valid", ser_valid, mq.size() > 0);
    chk("m_out", ser_out, mq.size() > 0 ? mq[0] : 1'b0);
    chk("m_fs", frame_start, mq.size() == W + P);
    chk("m_busy", busy, mq.size() > 0 || mhv);
    chk("m_rdy", load_ready, !mhv && !mrq);
  endtask
  task automatic add(input bit r, input bit l, input logic [W-1:0] d, input bit rdy, input bit v, input bit o, input bit fs, input bit bsy);
    vec_t e;
    e.rst = r; e.lv = l; e.d = d; e.rdy = rdy; e.v = v; e.o = o; e.fs = fs; e.bsy = bsy;
    tbl.push_back(e);
  endtask
  task automatic load_word(input logic [W-1:0] w);
    lv = 1; din = w; step();
    lv = 0; step();
  endtask
  initial begin
    bit a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    logic [2*(W+P)-1:0] got, exp_b2b;
    logic [2*(W+P)-1:0] fsm;
    logic [W-1:0] words[3] = '{8'h11, 8'h22, 8'h33};
    bit exp_q[$], got_q[$];
    int vc, idx, fs_cnt;
    bit prev_fs, acc;
    logic [3:0] win;
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 8'hA5, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) add(0, 0, 0, 1, 1, a5[k], k == 0, 1);
`ifdef SER_PARITY_EN
    add(0, 0, 0, 1, 1, 0, 0, 1);
`endif
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; lv = tbl[i].lv; din = tbl[i].d;
      step();
      chk($sformatf("tbl%0d_rdy", i), load_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), ser_valid, tbl[i].v);
      chk($sformatf("tbl%0d_out", i), ser_out, tbl[i].o);
      chk($sformatf("tbl%0d_fs", i), frame_start, tbl[i].fs);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
    end
    // back-to-back 0A then F0, second load during the first word
    load_word(8'h0A);
    vc = 0;
    for (int j = 0; j < 2 * (W + P); j++) begin
      got[2*(W+P)-1-j] = ser_out;
      fsm[j] = frame_start;
      vc += int'(ser_valid);
      lv = (j == 1); din = 8'hF0;
      step();
    end
    lv = 0;
`ifdef SER_PARITY_EN
    exp_b2b = {8'h0A, 1'b0, 8'hF0, 1'b0};
`else
    exp_b2b = 16'h0AF0;
`endif
    chk("b2b_bits", got, exp_b2b);
    chk("b2b_valid_cnt", vc, 2 * (W + P));
    chk("b2b_fs", fsm, (1 << (W + P)) | 1);
    chk("b2b_end_valid", ser_valid, 0);
    repeat (3) step();
    // backpressure: load_valid held high across three words
    idx = 0; fs_cnt = 0; prev_fs = 0;
    lv = 1; din = words[0];
    for (int c = 0; c < 60; c++) begin
      acc = lv && !mhv && !mrq;
      prev_fs = frame_start;
      step();
      if (ser_valid) got_q.push_back(ser_out);
      fs_cnt += int'(frame_start);
      if (acc) begin
        idx++;
        if (idx == 2) chk("bp_rdy_drop", load_ready, 0);
        if (idx == 3) chk("bp_acc3_at_reload", prev_fs, 1);
        if (idx == 3) lv = 0; else din = words[idx];
      end
    end
    chk("bp_accepts", idx, 3);
    chk("bp_frames", fs_cnt, 3);
    for (int w = 0; w < 3; w++) begin
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(words[w][i]);
      if (P == 1) exp_q.push_back(^words[w]);
    end
    chk("bp_len", got_q.size(), exp_q.size());
    chk("bp_stream", got_q == exp_q, 1);
    // reset at bit 3 of FF while 55 is held
    load_word(8'hFF);
    lv = 1; din = 8'h55; step();
    lv = 0; step(); step();
    rst = 1; step();
    chk("rst_valid", ser_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", load_ready, 0);
    rst = 0; step();
    chk("rst_rdy_after", load_ready, 1);
    vc = 0;
    repeat (30) begin step(); vc += int'(ser_valid); end
    chk("rst_no_emit", vc, 0);
`ifdef SER_PARITY_EN
    load_word(8'h07);
    vc = 0; got = '0;
    for (int j = 0; j < 10; j++) begin
      vc += int'(ser_valid);
      got = {got[2*(W+P)-2:0], ser_out & ser_valid};
      step();
    end
    chk("par07_bits", got[8:0], 9'b000001111);
    chk("par07_period", vc, 9);
    load_word(8'h03);
    vc = 0; got = '0;
    for (int j = 0; j < 10; j++) begin
      vc += int'(ser_valid);
      got = {got[2*(W+P)-2:0], ser_out & ser_valid};
      step();
    end
    chk("par03_bits", got[8:0], 9'b000000110);
    chk("par03_period", vc, 9);
`endif
    // downstream 1010 detector view of word 0A
    load_word(8'h0A);
    win = '0; vc = 0;
    for (int j = 0; j < 12; j++) begin
      if (ser_valid) begin
        win = {win[2:0], ser_out};
        vc += int'(win == 4'b1010);
      end
      step();
    end
    chk("det_1010_hits", vc, 1);
    // random traffic with occasional reset
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      lv = ($urandom_range(0, 2) != 0);
      din = W'($urandom);
      step();
    end
    rst = 0; lv = 0;
    repeat (25) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
